// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, parity modes and
// per-frame configuration latched at load.
package uart_pkg;

   localparam int CLKS_PER_BIT_9600_50M = 5208;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   // Parity is resolved to a single bit at load so mid-frame mode changes are inert.
   typedef struct packed {
      logic par_en;
      logic par_bit;
      logic two_stop;
   } frame_cfg_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: free-runs modulo CLK_DIV, pulses bit_end on the last
// cycle of each period, and restarts from zero on request.
module uart_baud_gen #(
   parameter int CLK_DIV = 5208
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic bit_end
);
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart || (cnt_q == LAST)) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign bit_end = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter draining a first-word-fall-through FIFO; frames run
// back-to-back with no idle bit when the FIFO stays non-empty.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = CLKS_PER_BIT_9600_50M
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  tx_fifo_empty,
   input  logic                  tx_enable,
   input  logic [1:0]            parity_mode,
   input  logic                  two_stop,
   output logic                  tx_rd_en,
   output logic                  txd,
   output logic                  busy,
   output logic                  frame_done
);
   localparam int BCW = $clog2(DATA_WIDTH);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

   tx_state_e             state_q, state_d;
   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   frame_cfg_t            cfg_q, cfg_d;
   logic                  txd_q, txd_d;
   logic                  busy_q, busy_d;
   logic                  rd_en_q, rd_en_d;
   logic                  done_q, done_d;
   logic                  bit_end, frame_end, load, baud_restart;

   // bit_cnt doubles as the stop-bit index in STOP.
   assign frame_end    = (state_q == ST_STOP) && bit_end && (bit_cnt_q == BCW'(cfg_q.two_stop));
   assign load         = tx_enable && !tx_fifo_empty && ((state_q == ST_IDLE) || frame_end);
   assign baud_restart = load || (state_q == ST_IDLE);

   uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
      .clk     (clk),
      .reset_n (reset_n),
      .restart (baud_restart),
      .bit_end (bit_end)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      cfg_d     = cfg_q;
      unique case (state_q)
         ST_START:  if (bit_end) begin
                       state_d   = ST_DATA;
                       bit_cnt_d = '0;
                    end
         ST_DATA:   if (bit_end) begin
                       if (bit_cnt_q == LAST_BIT) begin
                          bit_cnt_d = '0;
                          state_d   = cfg_q.par_en ? ST_PARITY : ST_STOP;
                       end else begin
                          bit_cnt_d = bit_cnt_q + 1'b1;
                          shift_d   = shift_q >> 1;
                       end
                    end
         ST_PARITY: if (bit_end) state_d = ST_STOP;
         ST_STOP:   if (frame_end)    state_d   = ST_IDLE;
                    else if (bit_end) bit_cnt_d = bit_cnt_q + 1'b1;
         default:   state_d = state_q;
      endcase
      if (load) begin
         state_d        = ST_START;
         bit_cnt_d      = '0;
         shift_d        = data;
         cfg_d.par_en   = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
         cfg_d.par_bit  = (^data) ^ (parity_mode == PAR_ODD);
         cfg_d.two_stop = two_stop;
      end

      rd_en_d = load;
      done_d  = frame_end;
      busy_d  = (state_d != ST_IDLE);
      unique case (state_d)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shift_d[0];
         ST_PARITY: txd_d = cfg_q.par_bit;
         default:   txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         cfg_q     <= '0;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         cfg_q     <= cfg_d;
         txd_q     <= txd_d;
         busy_q    <= busy_d;
         rd_en_q   <= rd_en_d;
         done_q    <= done_d;
      end
   end

   assign tx_rd_en   = rd_en_q;
   assign txd        = txd_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: FIFO model, frame scoreboard, table-driven frames
// plus hand-written corner sequences; 5- and 9-bit builds alongside.
module tb_uart_tx_frame;

   typedef struct { logic [15:0] bits; int nb; } frame_t;
   typedef struct { logic [7:0] d; logic [1:0] pm; logic ts; logic par; int nb; } vec_t;

   logic clk = 1'b0;
   logic reset_n;
   logic [7:0] data8;
   logic empty8, en8, ts8;
   logic [1:0] pm8;
   logic rd8, txd8, busy8, fd8;
   logic en59, e5, e9;
   logic [4:0] d5;
   logic [8:0] d9;
   logic rd5, txd5, busy5, fd5, rd9, txd9, busy9, fd9;

   int errors = 0, checks = 0, cyc = 0, rd_cnt = 0, fd_cnt = 0;
   bit mon_off = 1'b0, mon_busy = 1'b0, bad;
   logic [7:0] fifo8[$];
   frame_t sb[$];
   int rd_st[$];
   vec_t tbl[7];

   always #5 clk = ~clk;

   uart_tx_frame #(.DATA_WIDTH(8), .CLK_DIV(4)) dut8 (
      .clk(clk), .reset_n(reset_n), .data(data8), .tx_fifo_empty(empty8), .tx_enable(en8),
      .parity_mode(pm8), .two_stop(ts8), .tx_rd_en(rd8), .txd(txd8), .busy(busy8), .frame_done(fd8));
   uart_tx_frame #(.DATA_WIDTH(5), .CLK_DIV(4)) dut5 (
      .clk(clk), .reset_n(reset_n), .data(d5), .tx_fifo_empty(e5), .tx_enable(en59),
      .parity_mode(2'b00), .two_stop(1'b0), .tx_rd_en(rd5), .txd(txd5), .busy(busy5), .frame_done(fd5));
   uart_tx_frame #(.DATA_WIDTH(9), .CLK_DIV(4)) dut9 (
      .clk(clk), .reset_n(reset_n), .data(d9), .tx_fifo_empty(e9), .tx_enable(en59),
      .parity_mode(2'b00), .two_stop(1'b0), .tx_rd_en(rd9), .txd(txd9), .busy(busy9), .frame_done(fd9));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic refresh();
      empty8 = (fifo8.size() == 0);
      data8  = (fifo8.size() > 0) ? fifo8[0] : 8'h00;
   endtask

   // Queue a word in the FIFO model; optionally push its expected frame.
   task automatic push8(input logic [7:0] w, input logic par, input int nb, input bit to_sb);
      frame_t f;
      int idx = 9;
      f.bits = '0;
      f.nb   = nb;
      for (int j = 0; j < 8; j++) f.bits[1+j] = w[j];
      if (pm8 == 2'b01 || pm8 == 2'b10) begin
         f.bits[9] = par;
         idx = 10;
      end
      for (int j = idx; j < nb; j++) f.bits[j] = 1'b1;
      fifo8.push_back(w);
      refresh();
      if (to_sb) sb.push_back(f);
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (n < 400 && !(fifo8.size() == 0 && sb.size() == 0 && !busy8 && !mon_busy)) begin
         tick();
         n++;
      end
      chk(nm, n < 400, 1);
   endtask

   // FIFO pops and event counters, sampled mid-cycle.
   initial begin : popper
      logic [7:0] w;
      forever begin
         @(negedge clk);
         cyc++;
         if (rd8 === 1'b1) begin
            rd_cnt++;
            rd_st.push_back(cyc);
            if (fifo8.size() > 0) w = fifo8.pop_front();
            refresh();
         end
         if (fd8 === 1'b1) fd_cnt++;
      end
   end

   // Scoreboard monitor: each pop opens a frame, checked cycle by cycle.
   initial begin : mon
      frame_t f;
      logic [15:0] obs;
      bit err;
      forever begin
         @(negedge clk);
         while (rd8 === 1'b1 && !mon_off) begin
            mon_busy = 1'b1;
            err = 1'b0;
            obs = '0;
            chk("sb pop", sb.size() == 0, 0);
            if (sb.size() > 0) f = sb.pop_front();
            else begin
               f.bits = '1;
               f.nb   = 10;
            end
            for (int k = 0; k < f.nb * 4; k++) begin
               if (k % 4 == 0) obs[k/4] = txd8;
               else if (txd8 !== obs[k/4]) err = 1'b1;
               if (busy8 !== 1'b1) err = 1'b1;
               if (k > 0 && (rd8 !== 1'b0 || fd8 !== 1'b0)) err = 1'b1;
               @(negedge clk);
            end
            chk("frame bits", obs, f.bits);
            chk("frame ctl", err, 0);
            chk("frame_done", fd8, 1);
            mon_busy = 1'b0;
         end
      end
   end

   task automatic small_frame(input bit w9);
      int nb = w9 ? 11 : 7;
      int n = 0;
      logic [10:0] exp, obs;
      obs = '0;
      exp = w9 ? {1'b1, 9'h1A5, 1'b0} : {4'b0000, 1'b1, 5'b10110, 1'b0};
      if (w9) begin d9 = 9'h1A5; e9 = 1'b0; end
      else    begin d5 = 5'b10110; e5 = 1'b0; end
      while (n < 10 && (w9 ? rd9 : rd5) !== 1'b1) begin
         tick();
         n++;
      end
      chk(w9 ? "w9 pop" : "w5 pop", n < 10, 1);
      e5 = 1'b1;
      e9 = 1'b1;
      for (int k = 0; k < nb * 4; k++) begin
         if (k % 4 == 2) obs[k/4] = w9 ? txd9 : txd5;
         tick();
      end
      chk(w9 ? "w9 frame" : "w5 frame", obs, exp);
      chk(w9 ? "w9 done" : "w5 done", w9 ? fd9 : fd5, 1);
      if (w9) chk("w9 msb last", obs[9], 1'b1);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin : main
      int n, r0, f0;
      tbl[0] = '{8'h55, 2'b00, 1'b0, 1'b0, 10};
      tbl[1] = '{8'h07, 2'b01, 1'b0, 1'b1, 11};
      tbl[2] = '{8'h07, 2'b10, 1'b0, 1'b0, 11};
      tbl[3] = '{8'hFF, 2'b10, 1'b0, 1'b1, 11};
      tbl[4] = '{8'h80, 2'b01, 1'b1, 1'b1, 12};
      tbl[5] = '{8'h3C, 2'b11, 1'b1, 1'b0, 11};
      tbl[6] = '{8'h00, 2'b01, 1'b0, 1'b0, 11};

      reset_n = 1'b0; en8 = 1'b0; pm8 = 2'b00; ts8 = 1'b0;
      en59 = 1'b1; e5 = 1'b1; e9 = 1'b1; d5 = '0; d9 = '0;
      refresh();
      tick(); tick();
      chk("rst txd", txd8, 1);
      chk("rst rd_en", rd8, 0);
      chk("rst busy", busy8, 0);
      chk("rst done", fd8, 0);
      reset_n = 1'b1;
      en8 = 1'b1;

      bad = 1'b0;
      repeat (10) begin
         tick();
         if (txd8 !== 1'b1 || rd8 !== 1'b0 || busy8 !== 1'b0) bad = 1'b1;
      end
      chk("idle empty", bad, 0);

      en8 = 1'b0;
      push8(8'h55, 1'b0, 10, 1'b1);
      bad = 1'b0;
      repeat (10) begin
         tick();
         if (txd8 !== 1'b1 || rd8 !== 1'b0 || busy8 !== 1'b0) bad = 1'b1;
      end
      chk("idle disabled", bad, 0);
      en8 = 1'b1;
      wait_done("enable release");

      for (int i = 0; i < 7; i++) begin
         pm8 = tbl[i].pm;
         ts8 = tbl[i].ts;
         push8(tbl[i].d, tbl[i].par, tbl[i].nb, 1'b1);
         wait_done("table frame");
      end

      // Back-to-back, two stop bits: next start lands on the frame_done cycle.
      pm8 = 2'b00; ts8 = 1'b1;
      rd_st.delete();
      f0 = fd_cnt;
      push8(8'hA5, 1'b0, 11, 1'b1);
      push8(8'h3C, 1'b0, 11, 1'b1);
      wait_done("b2b drain");
      chk("b2b pops", rd_st.size(), 2);
      if (rd_st.size() == 2) chk("b2b spacing", rd_st[1] - rd_st[0], 44);
      chk("b2b dones", fd_cnt - f0, 2);

      // Config changed mid-frame must not affect the frame in flight.
      pm8 = 2'b01; ts8 = 1'b0;
      push8(8'h07, 1'b1, 11, 1'b1);
      n = 0;
      while (n < 20 && !mon_busy) begin tick(); n++; end
      repeat (6) tick();
      pm8 = 2'b00; ts8 = 1'b1;
      wait_done("cfg change");
      ts8 = 1'b0;

      // Enable dropped mid-frame with a word still queued.
      r0 = rd_cnt;
      push8(8'h11, 1'b0, 10, 1'b1);
      push8(8'h22, 1'b0, 10, 1'b0);
      n = 0;
      while (n < 20 && !mon_busy) begin tick(); n++; end
      repeat (10) tick();
      en8 = 1'b0;
      n = 0;
      while (n < 200 && (mon_busy || busy8)) begin tick(); n++; end
      chk("en drop finish", n < 200, 1);
      bad = 1'b0;
      repeat (20) begin
         tick();
         if (txd8 !== 1'b1 || rd8 !== 1'b0 || busy8 !== 1'b0) bad = 1'b1;
      end
      chk("en drop idle", bad, 0);
      chk("en drop pops", rd_cnt - r0, 1);
      fifo8.delete();
      refresh();
      en8 = 1'b1;

      // Reset pulse during data bit 3, then a clean frame after release.
      mon_off = 1'b1;
      push8(8'h33, 1'b0, 10, 1'b0);
      n = 0;
      while (n < 20 && rd8 !== 1'b1) begin tick(); n++; end
      chk("rst pop seen", n < 20, 1);
      repeat (17) tick();
      f0 = fd_cnt;
      reset_n = 1'b0;
      push8(8'h5A, 1'b0, 10, 1'b0);
      tick();
      chk("midrst txd", txd8, 1);
      chk("midrst busy", busy8, 0);
      chk("midrst done", fd8, 0);
      chk("midrst rd_en", rd8, 0);
      push8(8'h00, 1'b0, 10, 1'b0);
      fifo8.delete();
      fifo8.push_back(8'h5A);
      sb.delete();
      begin
         frame_t f;
         f.bits = 16'h0000;
         for (int j = 0; j < 8; j++) f.bits[1+j] = j[0] ? 1'b1 : 1'b0;
         f.bits[1+0] = 1'b0; f.bits[1+1] = 1'b1; f.bits[1+2] = 1'b0; f.bits[1+3] = 1'b1;
         f.bits[1+4] = 1'b1; f.bits[1+5] = 1'b0; f.bits[1+6] = 1'b1; f.bits[1+7] = 1'b0;
         f.bits[9] = 1'b1;
         f.nb = 10;
         sb.push_back(f);
      end
      refresh();
      mon_off = 1'b0;
      reset_n = 1'b1;
      wait_done("post reset frame");
      chk("midrst done count", fd_cnt - f0, 1);

      small_frame(1'b0);
      small_frame(1'b1);

      chk("sb empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
